// File: rtl/scct_irq_sequencer.sv
// Bus master in front of one scct timer: services its interrupt (read CH_IS, W1C ack,
// log {timestamp,status} into an event FIFO) and arbitrates a host slave port onto the same bus.
`ifndef SCCT_N_CHANNELS
`define SCCT_N_CHANNELS 4
`endif
`ifndef SCCT_PSC
`define SCCT_PSC 5'h00
`endif
`ifndef SCCT_CH_MS
`define SCCT_CH_MS 5'h01
`endif
`ifndef SCCT_CH_IS
`define SCCT_CH_IS 5'h04
`endif

module scct_irq_sequencer #(
   parameter int unsigned N_CH       = `SCCT_N_CHANNELS,
   parameter int unsigned TS_W       = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [4:0]  ADDR_IS    = `SCCT_CH_IS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           h_address,
   input  logic                 h_read,
   input  logic                 h_write,
   input  logic [31:0]          h_writedata,
   output logic [31:0]          h_readdata,
   output logic                 h_waitrequest,
   output logic [4:0]           m_address,
   output logic                 m_read,
   output logic                 m_write,
   output logic [31:0]          m_writedata,
   input  logic [31:0]          m_readdata,
   input  logic                 irq,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [TS_W+N_CH-1:0] evt_data,
   output logic                 evt_overrun
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = $clog2(RD_LATENCY + 1);
   localparam int unsigned EW = TS_W + N_CH;
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);
   localparam logic [LW-1:0] LAT_DONE = LW'(RD_LATENCY);

   typedef enum logic [3:0] {
      IDLE, S_RD, S_WAIT, S_CHK, S_ACK, S_GAP, H_WR, H_RD, H_RWAIT
   } state_t;

   state_t            r_state, w_next;
   logic [TS_W-1:0]   r_ts, r_ts_cap;
   logic [N_CH-1:0]   r_status, w_stat;
   logic              r_held;
   logic [LW-1:0]     r_lat;
   logic              r_rr_host;
   logic              r_overrun;
   logic [EW-1:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wp, r_rp;
   logic [PW:0]       r_cnt;
   logic              w_full, w_push, w_pop, w_hreq;
   logic              w_grant_host, w_grant_srv;

   assign w_hreq   = h_read | h_write;
   assign w_full   = (r_cnt == (PW+1)'(FIFO_DEPTH));
   assign w_push   = (r_state == S_ACK);
   assign w_pop    = (r_cnt != '0) && evt_ready;
   // readdata is only valid on the first S_CHK cycle; a full-FIFO stall keeps the captured copy
   assign w_stat   = r_held ? r_status : m_readdata[N_CH-1:0];

   assign evt_valid   = (r_cnt != '0);
   assign evt_data    = r_mem[r_rp];
   assign evt_overrun = r_overrun;

   always_comb begin
      w_next        = r_state;
      m_address     = '0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_writedata   = '0;
      h_waitrequest = 1'b1;
      h_readdata    = '0;
      w_grant_host  = 1'b0;
      w_grant_srv   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_hreq && (!irq || r_rr_host)) begin
               w_grant_host = 1'b1;
               w_next       = h_write ? H_WR : H_RD;
            end else if (irq) begin
               w_grant_srv = 1'b1;
               w_next      = S_RD;
            end
         end
         S_RD: begin
            m_read    = 1'b1;
            m_address = ADDR_IS;
            w_next    = (RD_LATENCY == 1) ? S_CHK : S_WAIT;
         end
         S_WAIT: if (r_lat == LAT_LAST) w_next = S_CHK;
         S_CHK: begin
            if (w_stat == '0)  w_next = IDLE;
            else if (!w_full)  w_next = S_ACK;
         end
         S_ACK: begin
            m_write                 = 1'b1;
            m_address               = ADDR_IS;
            m_writedata[N_CH-1:0]   = r_status;
            w_next                  = S_GAP;
         end
         S_GAP: w_next = IDLE;
         H_WR: begin
            m_write       = 1'b1;
            m_address     = h_address;
            m_writedata   = h_writedata;
            h_waitrequest = 1'b0;
            w_next        = IDLE;
         end
         H_RD: begin
            m_read    = 1'b1;
            m_address = h_address;
            w_next    = H_RWAIT;
         end
         H_RWAIT: begin
            if (r_lat == LAT_DONE) begin
               h_waitrequest = 1'b0;
               h_readdata    = m_readdata;
               w_next        = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ts      <= '0;
         r_ts_cap  <= '0;
         r_status  <= '0;
         r_held    <= 1'b0;
         r_lat     <= '0;
         r_rr_host <= 1'b1;
         r_overrun <= 1'b0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_next;
         r_ts    <= r_ts + 1'b1;
         if (w_grant_host) r_rr_host <= 1'b0;
         if (w_grant_srv)  r_rr_host <= 1'b1;
         if (r_state == S_RD || r_state == H_RD)          r_lat <= LW'(1);
         else if (r_state == S_WAIT || r_state == H_RWAIT) r_lat <= r_lat + LW'(1);
         if (r_state == S_RD) r_ts_cap <= r_ts;
         if (r_state == S_CHK) begin
            r_status <= w_stat;
            if (w_stat != '0 && w_full) begin
               r_held    <= 1'b1;
               r_overrun <= 1'b1;
            end
         end else begin
            r_held <= 1'b0;
         end
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {r_ts_cap, r_status};
   end

endmodule

// File: tb/tb_scct_irq_sequencer.sv
// Scoreboard bench: an scct slave model predicts acks, host transfers and logged events;
// negedge monitors pop and compare whatever the DUT presents.
`ifndef SCCT_N_CHANNELS
`define SCCT_N_CHANNELS 4
`endif
`ifndef SCCT_PSC
`define SCCT_PSC 5'h00
`endif
`ifndef SCCT_CH_MS
`define SCCT_CH_MS 5'h01
`endif
`ifndef SCCT_CH_IS
`define SCCT_CH_IS 5'h04
`endif

module tb_scct_irq_sequencer;
   localparam int unsigned N_CH = 4;
   localparam int unsigned TS_W = 16;
   localparam logic [4:0]  A_IS  = `SCCT_CH_IS;
   localparam logic [4:0]  A_PSC = `SCCT_PSC;
   localparam logic [4:0]  A_MS  = `SCCT_CH_MS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0]  h_address = '0;
   logic        h_read = 1'b0, h_write = 1'b0;
   logic [31:0] h_writedata = '0;
   logic [31:0] h_readdata;
   logic        h_waitrequest;
   logic [4:0]  m_address;
   logic        m_read, m_write;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = '0;
   logic        irq;
   logic        evt_valid;
   logic        evt_ready = 1'b0;
   logic [TS_W+N_CH-1:0] evt_data;
   logic        evt_overrun;

   always #5 clk = ~clk;

   scct_irq_sequencer #(.N_CH(N_CH), .TS_W(TS_W), .FIFO_DEPTH(8), .RD_LATENCY(1), .ADDR_IS(A_IS)) dut (
      .clk(clk), .rst(rst),
      .h_address(h_address), .h_read(h_read), .h_write(h_write), .h_writedata(h_writedata),
      .h_readdata(h_readdata), .h_waitrequest(h_waitrequest),
      .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .irq(irq),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .evt_overrun(evt_overrun)
   );

   int tests = 0;
   int fails = 0;
   logic [TS_W-1:0] ts_m = '0;
   int unsigned     cyc = 0;
   logic [N_CH-1:0] ch_is = '0;
   logic            spur = 1'b0;
   logic [N_CH-1:0] raise_bits = '0;
   logic            raise_spur = 1'b0;
   logic [31:0]     slave_regs [32];
   logic [31:0]     model_regs [32];
   logic            rd_pend = 1'b0;
   logic [31:0]     rd_val = '0;
   logic [TS_W+N_CH-1:0] exp_evt [$];
   logic [N_CH-1:0]      exp_ack [$];
   logic [36:0]          exp_hw  [$];
   logic [31:0]          exp_hr  [$];
   byte             grant_log [$];
   int unsigned     last_is_rd_cyc = 0, last_ack_cyc = 0;
   logic [TS_W-1:0] last_is_ts = '0;
   int              n_is_rd = 0, n_ack = 0;
   int              ready_mode = 1;

   assign irq = (|ch_is) | spur;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   // scct slave: readdata valid exactly one cycle after the read pulse, garbage otherwise
   always @(posedge clk) begin
      if (rst) ts_m <= '0;
      else     ts_m <= ts_m + 1'b1;
      cyc        <= cyc + 1;
      m_readdata <= rd_pend ? rd_val : $urandom;
   end

   always @(posedge clk) begin
      #1;
      evt_ready = (ready_mode == 2) ? ($urandom_range(3) != 0) : (ready_mode == 1);
   end

   always @(negedge clk) begin
      rd_pend = 1'b0;
      if (rst) begin
         exp_evt.delete();
         exp_ack.delete();
      end else begin
         chk("bus_rd_wr_exclusive", 64'(m_read & m_write), 64'd0);
         if (m_read) begin
            rd_pend = 1'b1;
            if (m_address == A_IS) begin
               rd_val = 32'(ch_is);
               grant_log.push_back("S");
               n_is_rd++;
               last_is_rd_cyc = cyc;
               last_is_ts     = ts_m;
               if (ch_is != '0) begin
                  exp_evt.push_back({ts_m, ch_is});
                  exp_ack.push_back(ch_is);
               end
               spur = 1'b0;
            end else begin
               rd_val = slave_regs[m_address];
               grant_log.push_back("H");
            end
         end
         if (m_write) begin
            if (m_address == A_IS) begin
               n_ack++;
               last_ack_cyc = cyc;
               if (exp_ack.size() == 0) unexpected("irq_ack", 64'(m_writedata));
               else chk("irq_ack_data", 64'(m_writedata), 64'(exp_ack.pop_front()));
               ch_is = ch_is & ~m_writedata[N_CH-1:0];
            end else begin
               grant_log.push_back("H");
               if (exp_hw.size() == 0) unexpected("host_wr", {27'd0, m_address, m_writedata});
               else chk("host_wr", {27'd0, m_address, m_writedata}, 64'(exp_hw.pop_front()));
               slave_regs[m_address] = m_writedata;
            end
         end
         if (h_read && !h_write && !h_waitrequest) begin
            if (exp_hr.size() == 0) unexpected("host_rd", 64'(h_readdata));
            else chk("host_rdata", 64'(h_readdata), 64'(exp_hr.pop_front()));
         end
         if (evt_valid && evt_ready) begin
            if (exp_evt.size() == 0) unexpected("evt_pop", 64'(evt_data));
            else chk("evt_data", 64'(evt_data), 64'(exp_evt.pop_front()));
         end
      end
      ch_is = ch_is | raise_bits;
      if (raise_spur) spur = 1'b1;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic raise(input logic [N_CH-1:0] b);
      raise_bits = b;
      @(negedge clk);
      #1 raise_bits = '0;
   endtask

   task automatic raise_spurious();
      raise_spur = 1'b1;
      @(negedge clk);
      #1 raise_spur = 1'b0;
   endtask

   task automatic host_wait(input string name);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!h_waitrequest) break;
      end
      if (k == 200) unexpected({name, "_timeout"}, 64'd200);
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [4:0] a, input logic [31:0] d);
      exp_hw.push_back({a, d});
      model_regs[a] = d;
      h_address = a; h_writedata = d; h_write = 1'b1;
      host_wait("host_wr");
      h_write = 1'b0;
   endtask

   task automatic host_read(input logic [4:0] a);
      exp_hr.push_back(model_regs[a]);
      h_address = a; h_read = 1'b1;
      host_wait("host_rd");
      h_read = 1'b0;
   endtask

   task automatic wait_acks(input int target, input string name);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (n_ack >= target) break;
      end
      if (k == 300) unexpected({name, "_ack_timeout"}, 64'(n_ack));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] a;
      int base, k;
      for (int i = 0; i < 32; i++) begin
         slave_regs[i] = '0;
         model_regs[i] = '0;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_m_read", 64'(m_read), 64'd0);
      chk("rst_m_write", 64'(m_write), 64'd0);
      chk("rst_m_address", 64'(m_address), 64'd0);
      chk("rst_m_writedata", 64'(m_writedata), 64'd0);
      chk("rst_h_readdata", 64'(h_readdata), 64'd0);
      chk("rst_h_waitrequest", 64'(h_waitrequest), 64'd1);
      chk("rst_evt_valid", 64'(evt_valid), 64'd0);
      chk("rst_evt_overrun", 64'(evt_overrun), 64'd0);
      step(1);
      rst = 1'b0;
      step(1);

      // 1: host write PSC=1, waitrequest low for one cycle only
      host_write(A_PSC, 32'd1);
      @(negedge clk);
      chk("wr_wreq_high_after", 64'(h_waitrequest), 64'd1);
      chk("wr_single_pulse", 64'(m_write), 64'd0);
      step(1);

      // 2: single irq, ack two cycles after the status read
      base = n_ack;
      raise(4'h1);
      wait_acks(base + 1, "t2");
      chk("t2_ack_latency", 64'(last_ack_cyc - last_is_rd_cyc), 64'd2);
      step(5);
      chk("t2_evt_drained", 64'(exp_evt.size()), 64'd0);

      // 3: irq and host read pending together twice -> host, servicer, host
      grant_log.delete();
      fork
         raise(4'h4);
         host_read(A_MS);
      join
      host_read(A_PSC);
      step(5);
      chk("t3_grants", 64'(grant_log.size()), 64'd3);
      if (grant_log.size() >= 3) begin
         chk("t3_grant0", 64'(grant_log[0]), 64'("H"));
         chk("t3_grant1", 64'(grant_log[1]), 64'("S"));
         chk("t3_grant2", 64'(grant_log[2]), 64'("H"));
      end

      // 4: spurious irq (CH_IS reads 0)
      base = n_ack; k = n_is_rd;
      raise_spurious();
      step(20);
      chk("t4_one_read", 64'(n_is_rd - k), 64'd1);
      chk("t4_no_ack", 64'(n_ack - base), 64'd0);
      chk("t4_no_evt", 64'(evt_valid), 64'd0);

      // random mix of irq bursts, host traffic and consumer back-pressure
      ready_mode = 2;
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(3))
            0: raise(N_CH'($urandom_range(1, (1 << N_CH) - 1)));
            1: begin
               do a = 5'($urandom_range(31)); while (a == A_IS);
               host_write(a, $urandom);
            end
            2: begin
               do a = 5'($urandom_range(31)); while (a == A_IS);
               host_read(a);
            end
            default: step($urandom_range(1, 6));
         endcase
      end
      ready_mode = 1;
      step(60);
      chk("rand_evt_empty", 64'(exp_evt.size()), 64'd0);
      chk("rand_ack_empty", 64'(exp_ack.size()), 64'd0);
      chk("rand_no_overrun", 64'(evt_overrun), 64'd0);

      // 5: FIFO full stall and overrun
      ready_mode = 0;
      step(3);
      for (int e = 0; e < 8; e++) begin
         base = n_ack;
         raise(N_CH'(1 << (e % N_CH)));
         wait_acks(base + 1, "t5");
         step(2);
      end
      base = n_ack;
      raise(4'h8);
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_ack.size() != 0) break;
      end
      step(10);
      chk("t5_overrun", 64'(evt_overrun), 64'd1);
      chk("t5_ack_held", 64'(n_ack - base), 64'd0);
      chk("t5_model_entries", 64'(exp_evt.size()), 64'd9);
      chk("t5_evt_valid", 64'(evt_valid), 64'd1);
      @(negedge clk);
      ready_mode = 1;
      @(negedge clk);
      ready_mode = 0;
      wait_acks(base + 1, "t5_release");
      step(3);
      chk("t5_overrun_sticky", 64'(evt_overrun), 64'd1);
      ready_mode = 1;
      step(30);
      chk("t5_drained", 64'(exp_evt.size()), 64'd0);
      chk("t5_evt_valid_low", 64'(evt_valid), 64'd0);

      // 6: timestamp wrap, then reset in the middle of a servicing sequence
      do_reset();
      @(negedge clk);
      chk("t6_overrun_cleared", 64'(evt_overrun), 64'd0);
      step(1);
      k = 0;
      while (ts_m != 16'hFFFF && k < 70000) begin
         step(1);
         k++;
      end
      base = n_ack;
      raise(4'h1);
      wait_acks(base + 1, "t6_wrap");
      chk("t6_wrap_ts", 64'(last_is_ts), 64'd0);
      step(5);
      chk("t6_wrap_evt_popped", 64'(exp_evt.size()), 64'd0);
      k = n_is_rd;
      raise(4'h2);
      for (int w = 0; w < 100; w++) begin
         if (n_is_rd != k) break;
         @(negedge clk);
      end
      base = n_ack;
      @(posedge clk);
      #1 rst = 1'b1;
      step(2);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_no_ack", 64'(n_ack - base), 64'd0);
      chk("t6_rst_fifo_empty", 64'(evt_valid), 64'd0);
      step(40);
      chk("end_evt_empty", 64'(exp_evt.size()), 64'd0);
      chk("end_ack_empty", 64'(exp_ack.size()), 64'd0);
      chk("end_host_empty", 64'(exp_hw.size() + exp_hr.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
